// File: rtl/uart_bus_interface_pkg.sv
// ----------------------------------------------------------------------------
// uart_defs : shared definitions for the memory-mapped UART slave.
//   - register offsets (wAddress[3:2])
//   - STATUS register bit positions
//   - TX / RX state encodings
//   - minimum effective bit divisor and the clamp helper
// ----------------------------------------------------------------------------
package uart_defs;

    localparam logic [1:0] REG_TXDATA  = 2'd0;
    localparam logic [1:0] REG_RXDATA  = 2'd1;
    localparam logic [1:0] REG_STATUS  = 2'd2;
    localparam logic [1:0] REG_DIVISOR = 2'd3;

    localparam int ST_TX_FULL   = 0;
    localparam int ST_TX_EMPTY  = 1;
    localparam int ST_RX_VALID  = 2;
    localparam int ST_RX_OVR    = 3;
    localparam int ST_TX_BUSY   = 4;
    localparam int ST_FRAME_ERR = 5;

    localparam logic [15:0] MIN_DIV = 16'd3;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } txState_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rxState_t;

    // Divisors below MIN_DIV leave too few clocks for the half-bit RX search.
    function automatic logic [15:0] effDivisor(input logic [15:0] div);
        return (div < MIN_DIV) ? MIN_DIV : div;
    endfunction

endpackage

// File: rtl/uart_bus_interface_if.sv
// ----------------------------------------------------------------------------
// uart_bus_if : CPU data-bus transaction bundle.
//   master : drives strobes, byte lanes, address and write data; reads wReadData
//   slave  : the reverse (used by uart_bus_interface)
// ----------------------------------------------------------------------------
interface uart_bus_if;
    logic        wReadEnable;
    logic        wWriteEnable;
    logic [3:0]  wByteEnable;
    logic [31:0] wAddress;
    logic [31:0] wWriteData;
    logic [31:0] wReadData;

    modport master (
        output wReadEnable, wWriteEnable, wByteEnable, wAddress, wWriteData,
        input  wReadData
    );

    modport slave (
        input  wReadEnable, wWriteEnable, wByteEnable, wAddress, wWriteData,
        output wReadData
    );
endinterface

// File: rtl/uart_bus_interface_tx_fifo.sv
// ----------------------------------------------------------------------------
// uart_tx_fifo : DEPTH x 8 synchronous FIFO for transmit bytes.
//   iCLK, iRST (async, active-low)
//   iPush/iPushData : enqueue; accepted when not full, or when full and
//                     a pop happens in the same cycle
//   iPop            : dequeue (ignored when empty)
//   oHeadData       : combinational head entry
//   oFull, oEmpty   : occupancy flags
// ----------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic       iPush,
    input  logic [7:0] iPushData,
    input  logic       iPop,
    output logic [7:0] oHeadData,
    output logic       oFull,
    output logic       oEmpty
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wrPtr;
    logic [AW:0] rdPtr;
    logic        pushOk;
    logic        popOk;

    // Extra MSB distinguishes full from empty when the index bits match.
    assign oEmpty = (wrPtr == rdPtr);
    assign oFull  = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);

    assign popOk  = iPop && !oEmpty;
    assign pushOk = iPush && (!oFull || popOk);

    assign oHeadData = mem[rdPtr[AW-1:0]];

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (pushOk) wrPtr <= wrPtr + 1'b1;
            if (popOk)  rdPtr <= rdPtr + 1'b1;
        end
    end

    always_ff @(posedge iCLK) begin
        if (pushOk) mem[wrPtr[AW-1:0]] <= iPushData;
    end
endmodule

// File: rtl/uart_bus_interface.sv
// ----------------------------------------------------------------------------
// uart_bus_interface : memory-mapped 8N1 UART slave.
//   iCLK  : core clock          iRST : async active-low reset
//   bus   : uart_bus_if.slave (one-cycle read/write, combinational read data)
//   iRX   : async serial input  oTX  : serial output (idle high)
//   oIRQ  : high while a received byte is waiting
// Registers: 0x0 TXDATA, 0x4 RXDATA, 0x8 STATUS, 0xC DIVISOR.
// ----------------------------------------------------------------------------
module uart_bus_interface
    import uart_defs::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'hFF20_0000,
    parameter int          TX_DEPTH  = 8,
    parameter logic [15:0] DIV_RESET = 16'd433
) (
    input  logic       iCLK,
    input  logic       iRST,
    uart_bus_if.slave  bus,
    input  logic       iRX,
    output logic       oTX,
    output logic       oIRQ
);
    // ---------------- bus decode ----------------
    logic       sel;
    logic [1:0] regSel;
    logic       txPush, rxReadClr, statusWr;

    assign sel       = (bus.wAddress[31:4] == BASE_ADDR[31:4]);
    assign regSel    = bus.wAddress[3:2];
    assign txPush    = bus.wWriteEnable && sel && (regSel == REG_TXDATA) && bus.wByteEnable[0];
    assign rxReadClr = bus.wReadEnable && sel && (regSel == REG_RXDATA);
    assign statusWr  = bus.wWriteEnable && sel && (regSel == REG_STATUS) && bus.wByteEnable[0];

    logic unusedBits;
    assign unusedBits = &{1'b0, bus.wWriteData[31:16], bus.wAddress[1:0], bus.wByteEnable[3:2]};

    // ---------------- divisor ----------------
    logic [15:0] divisor;
    logic [15:0] effDiv;
    assign effDiv = effDivisor(divisor);

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            divisor <= DIV_RESET;
        end else if (bus.wWriteEnable && sel && (regSel == REG_DIVISOR)) begin
            if (bus.wByteEnable[0]) divisor[7:0]  <= bus.wWriteData[7:0];
            if (bus.wByteEnable[1]) divisor[15:8] <= bus.wWriteData[15:8];
        end
    end

    // ---------------- TX FIFO ----------------
    logic [7:0] fifoHead;
    logic       fifoFull, fifoEmpty, txPop;

    uart_tx_fifo #(.DEPTH(TX_DEPTH)) uTxFifo (
        .iCLK      (iCLK),
        .iRST      (iRST),
        .iPush     (txPush),
        .iPushData (bus.wWriteData[7:0]),
        .iPop      (txPop),
        .oHeadData (fifoHead),
        .oFull     (fifoFull),
        .oEmpty    (fifoEmpty)
    );

    // ---------------- TX FSM ----------------
    txState_t    txState, txNext;
    logic [15:0] txCnt, txCntNext;
    logic [2:0]  txBit, txBitNext;
    logic [7:0]  txShift;
    logic        txLoad, txShiftEn, txBusy;

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            txState <= TX_IDLE;
            txCnt   <= '0;
            txBit   <= '0;
        end else begin
            txState <= txNext;
            txCnt   <= txCntNext;
            txBit   <= txBitNext;
        end
    end

    always_comb begin
        txNext    = txState;
        txCntNext = txCnt;
        txBitNext = txBit;
        txPop     = 1'b0;
        txLoad    = 1'b0;
        txShiftEn = 1'b0;
        unique case (txState)
            TX_IDLE: begin
                if (!fifoEmpty) begin
                    txNext    = TX_START;
                    txPop     = 1'b1;
                    txLoad    = 1'b1;
                    txCntNext = effDiv;
                end
            end
            TX_START: begin
                if (txCnt == '0) begin
                    txNext    = TX_DATA;
                    txCntNext = effDiv;
                    txBitNext = '0;
                end else begin
                    txCntNext = txCnt - 1'b1;
                end
            end
            TX_DATA: begin
                if (txCnt == '0) begin
                    txCntNext = effDiv;
                    txShiftEn = 1'b1;
                    if (txBit == 3'd7) txNext = TX_STOP;
                    else               txBitNext = txBit + 3'd1;
                end else begin
                    txCntNext = txCnt - 1'b1;
                end
            end
            TX_STOP: begin
                if (txCnt == '0) begin
                    // Chain straight into the next frame when data is queued.
                    if (!fifoEmpty) begin
                        txNext    = TX_START;
                        txPop     = 1'b1;
                        txLoad    = 1'b1;
                        txCntNext = effDiv;
                    end else begin
                        txNext = TX_IDLE;
                    end
                end else begin
                    txCntNext = txCnt - 1'b1;
                end
            end
            default: txNext = TX_IDLE;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (txLoad)         txShift <= fifoHead;
        else if (txShiftEn) txShift <= {1'b1, txShift[7:1]};
    end

    // Decoded from state flops, so reset forces the line high asynchronously.
    assign oTX    = (txState == TX_START) ? 1'b0 :
                    (txState == TX_DATA)  ? txShift[0] : 1'b1;
    assign txBusy = (txState != TX_IDLE);

    // ---------------- RX synchronizer ----------------
    logic rxMeta, rxSync, rxPrev;

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            rxMeta <= 1'b1;
            rxSync <= 1'b1;
            rxPrev <= 1'b1;
        end else begin
            rxMeta <= iRX;
            rxSync <= rxMeta;
            rxPrev <= rxSync;
        end
    end

    // ---------------- RX FSM ----------------
    rxState_t    rxState, rxNext;
    logic [15:0] rxCnt, rxCntNext;
    logic [2:0]  rxBit, rxBitNext;
    logic [7:0]  rxShift, rxByte;
    logic        rxShiftEn, rxDone, rxErr;
    logic        rxValid, rxOverrun, rxFrameErr;

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            rxState <= RX_IDLE;
            rxCnt   <= '0;
            rxBit   <= '0;
        end else begin
            rxState <= rxNext;
            rxCnt   <= rxCntNext;
            rxBit   <= rxBitNext;
        end
    end

    always_comb begin
        rxNext    = rxState;
        rxCntNext = rxCnt;
        rxBitNext = rxBit;
        rxShiftEn = 1'b0;
        rxDone    = 1'b0;
        rxErr     = 1'b0;
        unique case (rxState)
            RX_IDLE: begin
                if (rxPrev && !rxSync) begin
                    rxNext    = RX_START;
                    rxCntNext = effDiv >> 1;
                end
            end
            RX_START: begin
                if (rxCnt == '0) begin
                    // Mid start bit: a high line means the edge was a glitch.
                    if (!rxSync) begin
                        rxNext    = RX_DATA;
                        rxCntNext = effDiv;
                        rxBitNext = '0;
                    end else begin
                        rxNext = RX_IDLE;
                    end
                end else begin
                    rxCntNext = rxCnt - 1'b1;
                end
            end
            RX_DATA: begin
                if (rxCnt == '0) begin
                    rxShiftEn = 1'b1;
                    rxCntNext = effDiv;
                    if (rxBit == 3'd7) rxNext = RX_STOP;
                    else               rxBitNext = rxBit + 3'd1;
                end else begin
                    rxCntNext = rxCnt - 1'b1;
                end
            end
            RX_STOP: begin
                if (rxCnt == '0) begin
                    rxDone = rxSync;
                    rxErr  = !rxSync;
                    rxNext = RX_IDLE;
                end else begin
                    rxCntNext = rxCnt - 1'b1;
                end
            end
            default: rxNext = RX_IDLE;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (rxShiftEn) rxShift <= {rxSync, rxShift[7:1]};
        if (rxDone)    rxByte  <= rxShift;
    end

    // A completing byte wins over a same-cycle RXDATA read; overrun is only
    // flagged when the old byte was genuinely left unread.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            rxValid    <= 1'b0;
            rxOverrun  <= 1'b0;
            rxFrameErr <= 1'b0;
        end else begin
            if (rxDone)         rxValid <= 1'b1;
            else if (rxReadClr) rxValid <= 1'b0;

            if (rxDone && rxValid && !rxReadClr)            rxOverrun <= 1'b1;
            else if (statusWr && bus.wWriteData[ST_RX_OVR]) rxOverrun <= 1'b0;

            if (rxErr)                                         rxFrameErr <= 1'b1;
            else if (statusWr && bus.wWriteData[ST_FRAME_ERR]) rxFrameErr <= 1'b0;
        end
    end

    assign oIRQ = rxValid;

    // ---------------- read mux ----------------
    always_comb begin
        bus.wReadData = '0;
        if (bus.wReadEnable && sel) begin
            unique case (regSel)
                REG_RXDATA:  bus.wReadData = {23'b0, rxValid, rxByte};
                REG_STATUS: begin
                    bus.wReadData[ST_TX_FULL]   = fifoFull;
                    bus.wReadData[ST_TX_EMPTY]  = fifoEmpty;
                    bus.wReadData[ST_RX_VALID]  = rxValid;
                    bus.wReadData[ST_RX_OVR]    = rxOverrun;
                    bus.wReadData[ST_TX_BUSY]   = txBusy;
                    bus.wReadData[ST_FRAME_ERR] = rxFrameErr;
                end
                REG_DIVISOR: bus.wReadData = {16'b0, divisor};
                default:     bus.wReadData = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_bus_interface.sv
// ----------------------------------------------------------------------------
// tb_uart_bus_interface : directed bench for uart_bus_interface.
// ----------------------------------------------------------------------------
module tb_uart_bus_interface;
    localparam logic [31:0] BASE = 32'hFF20_0000;
    localparam logic [31:0] A_TX = BASE + 32'h0;
    localparam logic [31:0] A_RX = BASE + 32'h4;
    localparam logic [31:0] A_ST = BASE + 32'h8;
    localparam logic [31:0] A_DV = BASE + 32'hC;

    logic iCLK = 1'b0;
    logic iRST = 1'b0;
    logic iRX  = 1'b1;
    logic oTX, oIRQ;

    int checks = 0;
    int errors = 0;

    uart_bus_if busIf ();

    uart_bus_interface #(
        .BASE_ADDR (BASE),
        .TX_DEPTH  (8),
        .DIV_RESET (16'd433)
    ) dut (
        .iCLK (iCLK),
        .iRST (iRST),
        .bus  (busIf.slave),
        .iRX  (iRX),
        .oTX  (oTX),
        .oIRQ (oIRQ)
    );

    always #5 iCLK = ~iCLK;

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic busWrite(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
        @(posedge iCLK);
        #1;
        busIf.wWriteEnable = 1'b1;
        busIf.wAddress     = addr;
        busIf.wWriteData   = data;
        busIf.wByteEnable  = be;
        @(posedge iCLK);
        #1;
        busIf.wWriteEnable = 1'b0;
        busIf.wByteEnable  = 4'h0;
    endtask

    task automatic busRead(input logic [31:0] addr, output logic [31:0] data);
        @(posedge iCLK);
        #1;
        busIf.wReadEnable = 1'b1;
        busIf.wAddress    = addr;
        @(negedge iCLK);
        data = busIf.wReadData;
        @(posedge iCLK);
        #1;
        busIf.wReadEnable = 1'b0;
    endtask

    // Drive one 8N1 frame on iRX, bitLen clocks per bit.
    task automatic sendRx(input logic [7:0] b, input logic stopBit, input int bitLen);
        logic [9:0] frame;
        frame = {stopBit, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            @(posedge iCLK);
            #1;
            iRX = frame[k];
            repeat (bitLen - 1) @(posedge iCLK);
        end
        @(posedge iCLK);
        #1;
        iRX = 1'b1;
    endtask

    // Serial monitor on oTX: collects bytes and the negedge count before each start bit.
    int         txBitLen = 4;
    logic [7:0] txBytes[$];
    int         txGaps[$];

    initial begin
        forever begin
            int         gap;
            logic [7:0] b;
            gap = 0;
            do begin
                @(negedge iCLK);
                gap++;
            end while (oTX !== 1'b0);
            repeat (txBitLen / 2) @(posedge iCLK);
            @(negedge iCLK);
            for (int k = 0; k < 8; k++) begin
                repeat (txBitLen) @(posedge iCLK);
                @(negedge iCLK);
                b[k] = oTX;
            end
            repeat (txBitLen) @(posedge iCLK);
            @(negedge iCLK);
            txBytes.push_back(b);
            txGaps.push_back(gap);
        end
    end

    initial begin
        logic [31:0] rd;
        logic [9:0]  expBits;

        busIf.wReadEnable  = 1'b0;
        busIf.wWriteEnable = 1'b0;
        busIf.wByteEnable  = 4'h0;
        busIf.wAddress     = '0;
        busIf.wWriteData   = '0;

        repeat (3) @(posedge iCLK);
        #2 iRST = 1'b1;

        // Reset state
        @(negedge iCLK);
        checkEq("rst_oTX", {31'b0, oTX}, 32'd1);
        checkEq("rst_oIRQ", {31'b0, oIRQ}, 32'd0);
        checkEq("rst_rdata_idle", busIf.wReadData, 32'h0);
        busRead(A_ST, rd);
        checkEq("rst_status", rd, 32'h02);
        busRead(A_DV, rd);
        checkEq("rst_divisor", rd, 32'd433);
        busRead(32'hFF21_0008, rd);
        checkEq("unselected_read", rd, 32'h0);

        // Divisor lanes
        busWrite(A_DV, 32'h0000_0003, 4'b0011);
        busRead(A_DV, rd);
        checkEq("div_write", rd, 32'd3);
        busWrite(A_DV, 32'h0000_AB07, 4'b0001);
        busRead(A_DV, rd);
        checkEq("div_lane0_only", rd, 32'd7);
        busWrite(A_DV, 32'h0000_0003, 4'b0011);

        // Single TX frame 0xA5 at D=3
        expBits = {1'b1, 8'hA5, 1'b0};
        busWrite(A_TX, 32'h0000_00A5, 4'b0001);
        @(negedge iCLK);
        checkEq("tx_before_start", {31'b0, oTX}, 32'd1);
        @(posedge iCLK);
        @(negedge iCLK);
        checkEq("tx_start_edge", {31'b0, oTX}, 32'd0);
        @(posedge iCLK);
        for (int k = 0; k < 10; k++) begin
            @(negedge iCLK);
            checkEq($sformatf("tx_a5_bit%0d", k), {31'b0, oTX}, {31'b0, expBits[k]});
            repeat (4) @(posedge iCLK);
        end
        busRead(A_ST, rd);
        checkEq("tx_done_status", rd, 32'h02);

        // Burst: 10 back-to-back writes, the 10th hits a full FIFO
        @(posedge iCLK);
        #1;
        busIf.wWriteEnable = 1'b1;
        busIf.wByteEnable  = 4'b0001;
        busIf.wAddress     = A_TX;
        busIf.wWriteData   = 32'h10;
        for (int i = 1; i < 10; i++) begin
            @(posedge iCLK);
            #1;
            busIf.wWriteData = 32'h10 + i;
        end
        @(posedge iCLK);
        #1;
        busIf.wWriteEnable = 1'b0;
        busIf.wByteEnable  = 4'h0;
        busRead(A_ST, rd);
        checkEq("burst_full_status", rd, 32'h11);

        for (int i = 0; i < 3000 && txBytes.size() < 10; i++) @(posedge iCLK);
        repeat (100) @(posedge iCLK);
        checkEq("tx_frame_count", txBytes.size(), 32'd10);
        if (txBytes.size() >= 10) begin
            checkEq("tx_first_byte", {24'b0, txBytes[0]}, 32'hA5);
            for (int i = 1; i < 10; i++) begin
                checkEq($sformatf("burst_byte%0d", i - 1), {24'b0, txBytes[i]}, 32'h10 + i - 1);
                if (i >= 2) checkEq($sformatf("burst_gap%0d", i - 1), txGaps[i], 32'd2);
            end
        end
        busRead(A_ST, rd);
        checkEq("burst_done_status", rd, 32'h02);

        // RX at D=7
        busWrite(A_DV, 32'h0000_0007, 4'b0011);
        sendRx(8'h3C, 1'b1, 8);
        repeat (4) @(posedge iCLK);
        @(negedge iCLK);
        checkEq("rx_irq_high", {31'b0, oIRQ}, 32'd1);
        busRead(A_ST, rd);
        checkEq("rx_status_valid", rd, 32'h06);
        busRead(A_RX, rd);
        checkEq("rx_data_3c", rd, 32'h13C);
        busRead(A_ST, rd);
        checkEq("rx_status_cleared", rd, 32'h02);
        checkEq("rx_irq_low", {31'b0, oIRQ}, 32'd0);

        // Overrun
        sendRx(8'h5A, 1'b1, 8);
        sendRx(8'hC3, 1'b1, 8);
        repeat (4) @(posedge iCLK);
        busRead(A_ST, rd);
        checkEq("ovr_status", rd, 32'h0E);
        busRead(A_RX, rd);
        checkEq("ovr_data", rd, 32'h1C3);
        busRead(A_ST, rd);
        checkEq("ovr_after_read", rd, 32'h0A);
        busWrite(A_ST, 32'h08, 4'b0001);
        busRead(A_ST, rd);
        checkEq("ovr_cleared", rd, 32'h02);

        // Framing error
        sendRx(8'h77, 1'b0, 8);
        repeat (12) @(posedge iCLK);
        busRead(A_ST, rd);
        checkEq("frame_err_status", rd, 32'h22);
        busWrite(A_ST, 32'h20, 4'b0001);
        busRead(A_ST, rd);
        checkEq("frame_err_cleared", rd, 32'h02);

        // One-clock glitch
        @(posedge iCLK);
        #1 iRX = 1'b0;
        @(posedge iCLK);
        #1 iRX = 1'b1;
        repeat (120) @(posedge iCLK);
        busRead(A_ST, rd);
        checkEq("glitch_status", rd, 32'h02);
        checkEq("glitch_irq", {31'b0, oIRQ}, 32'd0);

        // Reset mid-frame
        busWrite(A_TX, 32'h0000_0000, 4'b0001);
        repeat (10) @(posedge iCLK);
        @(negedge iCLK);
        checkEq("midframe_tx_low", {31'b0, oTX}, 32'd0);
        #2 iRST = 1'b0;
        #1;
        checkEq("async_rst_oTX", {31'b0, oTX}, 32'd1);
        repeat (2) @(posedge iCLK);
        #2 iRST = 1'b1;
        busRead(A_ST, rd);
        checkEq("post_rst_status", rd, 32'h02);
        busRead(A_DV, rd);
        checkEq("post_rst_divisor", rd, 32'd433);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
